// File: rtl/snake_step_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the snake game sequencer.
// Imported by the controller top and its button sub-module.
package snake_step_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_RUN  = 2'd1;
    localparam logic [1:0] GS_OVER = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOOD,
        ST_WAIT,
        ST_STEP,
        ST_OVER
    } state_e;

    // Opposite pairs share the upper bit and differ only in the lower one.
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return dir ^ 2'b01;
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Request/done handshakes between the game sequencer (master) and the
// snake-body / food-placer datapath (slave).
interface snake_step_ctrl_if;

    logic       game_clr;
    logic       step_req;
    logic [1:0] step_dir;
    logic       step_done;
    logic       step_hit;
    logic       step_ate;
    logic       food_req;
    logic       food_done;

    modport master (
        output game_clr, step_req, step_dir, food_req,
        input  step_done, step_hit, step_ate, food_done
    );

    modport slave (
        input  game_clr, step_req, step_dir, food_req,
        output step_done, step_hit, step_ate, food_done
    );

endinterface

// File: rtl/snake_step_ctrl_btn_debounce.sv
// One push button: 2-FF synchroniser, stability counter and a registered
// one-cycle pulse on each rising edge of the debounced level.
module snake_step_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The debounced level only flips after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: direction latch from debounced buttons, frame-paced
// moves, food placement requests, score and speed tracking.
module snake_step_ctrl
    import snake_step_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_STEP_INIT = 8,
    parameter int FRAMES_PER_STEP_MIN  = 2,
    parameter int SPEEDUP_EVERY        = 4,
    parameter int SCORE_W              = 10,
    parameter int DEBOUNCE_CYCLES      = 500000
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               sw_up,
    input  logic               sw_down,
    input  logic               sw_left,
    input  logic               sw_right,
    input  logic               start,
    input  logic               frame_tick,
    snake_step_ctrl_if.master  hs,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         speed
);

    localparam int FC_W = $clog2(SPEEDUP_EVERY + 1);

    logic [3:0] sw_raw;
    logic [3:0] press;

    assign sw_raw = {sw_right, sw_left, sw_down, sw_up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        snake_step_ctrl_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (CLOCK_50),
            .rst    (rst),
            .btn_raw(sw_raw[g]),
            .press  (press[g])
        );
    end

    state_e             state_q, state_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic [FC_W-1:0]    food_cnt_q, food_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         speed_q, speed_d;
    logic [1:0]         dir_cur_q, dir_cur_d;
    logic [1:0]         dir_pend_q, dir_pend_d;
    logic               start_prev_q, start_prev_d;
    logic               game_clr_q, game_clr_d;
    logic               step_req_q, step_req_d;
    logic [1:0]         step_dir_q, step_dir_d;
    logic               food_req_q, food_req_d;
    logic [1:0]         game_state_q, game_state_d;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        food_cnt_d   = food_cnt_q;
        score_d      = score_q;
        speed_d      = speed_q;
        dir_cur_d    = dir_cur_q;
        dir_pend_d   = dir_pend_q;
        start_prev_d = start;
        game_clr_d   = 1'b0;
        step_req_d   = step_req_q;
        step_dir_d   = step_dir_q;
        food_req_d   = food_req_q;
        game_state_d = game_state_q;

        // Walk lowest to highest priority so UP overrides the others.
        for (int i = 3; i >= 0; i--) begin
            if (press[i] && (2'(i) != opposite_dir(dir_cur_q))) begin
                dir_pend_d = 2'(i);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !start_prev_q) begin
                    game_clr_d  = 1'b1;
                    dir_cur_d   = DIR_RIGHT;
                    dir_pend_d  = DIR_RIGHT;
                    score_d     = '0;
                    speed_d     = 4'(FRAMES_PER_STEP_INIT);
                    food_cnt_d  = '0;
                    frame_cnt_d = '0;
                    food_req_d  = 1'b1;
                    state_d     = ST_FOOD;
                end
            end
            ST_FOOD: begin
                if (hs.food_done) begin
                    food_req_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frame_cnt_q == speed_q) begin
                    frame_cnt_d = '0;
                    step_req_d  = 1'b1;
                    step_dir_d  = dir_pend_q;
                    dir_cur_d   = dir_pend_q;
                    state_d     = ST_STEP;
                end else if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end
            end
            ST_STEP: begin
                if (hs.step_done) begin
                    step_req_d = 1'b0;
                    if (hs.step_hit) begin
                        state_d = ST_OVER;
                    end else if (hs.step_ate) begin
                        if (score_q != '1) begin
                            score_d = score_q + 1'b1;
                        end
                        if (food_cnt_q == FC_W'(SPEEDUP_EVERY - 1)) begin
                            food_cnt_d = '0;
                            if (speed_q > 4'(FRAMES_PER_STEP_MIN)) begin
                                speed_d = speed_q - 4'd1;
                            end else begin
                                speed_d = 4'(FRAMES_PER_STEP_MIN);
                            end
                        end else begin
                            food_cnt_d = food_cnt_q + 1'b1;
                        end
                        food_req_d = 1'b1;
                        state_d    = ST_FOOD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_OVER: begin
                step_req_d = 1'b0;
                food_req_d = 1'b0;
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: game_state_d = GS_IDLE;
            ST_OVER: game_state_d = GS_OVER;
            default: game_state_d = GS_RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            food_cnt_q   <= '0;
            score_q      <= '0;
            speed_q      <= 4'(FRAMES_PER_STEP_INIT);
            dir_cur_q    <= DIR_RIGHT;
            dir_pend_q   <= DIR_RIGHT;
            start_prev_q <= 1'b0;
            game_clr_q   <= 1'b0;
            step_req_q   <= 1'b0;
            step_dir_q   <= DIR_RIGHT;
            food_req_q   <= 1'b0;
            game_state_q <= GS_IDLE;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            food_cnt_q   <= food_cnt_d;
            score_q      <= score_d;
            speed_q      <= speed_d;
            dir_cur_q    <= dir_cur_d;
            dir_pend_q   <= dir_pend_d;
            start_prev_q <= start_prev_d;
            game_clr_q   <= game_clr_d;
            step_req_q   <= step_req_d;
            step_dir_q   <= step_dir_d;
            food_req_q   <= food_req_d;
            game_state_q <= game_state_d;
        end
    end

    assign hs.game_clr = game_clr_q;
    assign hs.step_req = step_req_q;
    assign hs.step_dir = step_dir_q;
    assign hs.food_req = food_req_q;
    assign game_state  = game_state_q;
    assign score       = score_q;
    assign speed       = speed_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed plus randomized bench for snake_step_ctrl against a game-level
// model: foods eaten, pace derived from foods, and the direction rule.
module tb_snake_step_ctrl;

    localparam int INIT  = 8;
    localparam int MIN   = 2;
    localparam int EVERY = 4;
    localparam int SW    = 5;
    localparam int DEB   = 4;
    localparam int MAXS  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_up, sw_down, sw_left, sw_right;
    logic          start;
    logic          frame_tick;
    logic [1:0]    game_state;
    logic [SW-1:0] score;
    logic [3:0]    speed;

    int total = 0;
    int bad   = 0;

    int m_foods;
    int m_dir_cur;
    int m_dir_pend;

    snake_step_ctrl_if hs ();

    always #10 clk = ~clk;

    snake_step_ctrl #(
        .FRAMES_PER_STEP_INIT(INIT),
        .FRAMES_PER_STEP_MIN (MIN),
        .SPEEDUP_EVERY       (EVERY),
        .SCORE_W             (SW),
        .DEBOUNCE_CYCLES     (DEB)
    ) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .sw_up     (sw_up),
        .sw_down   (sw_down),
        .sw_left   (sw_left),
        .sw_right  (sw_right),
        .start     (start),
        .frame_tick(frame_tick),
        .hs        (hs),
        .game_state(game_state),
        .score     (score),
        .speed     (speed)
    );

    // Game-level model: pace and score follow directly from the food total.
    function automatic int modelSpeed();
        int s;
        s = INIT - (m_foods / EVERY);
        return (s < MIN) ? MIN : s;
    endfunction

    function automatic int modelScore();
        return (m_foods > MAXS) ? MAXS : m_foods;
    endfunction

    function automatic int oppositeOf(input int d);
        return (d % 2 == 0) ? d + 1 : d - 1;
    endfunction

    function automatic logic sigVal(input int which);
        case (which)
            0:       return hs.step_req;
            1:       return hs.food_req;
            default: return hs.game_clr;
        endcase
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitHigh(input int which, input int budget, input string tag);
        int cnt = 0;
        while (sigVal(which) !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
        checkOutput(tag, {31'd0, sigVal(which)}, 32'd1);
    endtask

    task automatic setButton(input int dir, input logic v);
        case (dir)
            0:       sw_up    = v;
            1:       sw_down  = v;
            2:       sw_left  = v;
            default: sw_right = v;
        endcase
    endtask

    // Stable press (updates the model) or a bounce that never settles long enough.
    task automatic applyStimulus(input int dir, input bit stable);
        if (stable) begin
            setButton(dir, 1'b1);
            tick(12);
            setButton(dir, 1'b0);
            tick(12);
            if (dir != oppositeOf(m_dir_cur)) m_dir_pend = dir;
        end else begin
            setButton(dir, 1'b1); tick(3);
            setButton(dir, 1'b0); tick(2);
            setButton(dir, 1'b1); tick(2);
            setButton(dir, 1'b0); tick(1);
            setButton(dir, 1'b1); tick(3);
            setButton(dir, 1'b0); tick(12);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        sw_up = 1'b0; sw_down = 1'b0; sw_left = 1'b0; sw_right = 1'b0;
        start = 1'b0; frame_tick = 1'b0;
        hs.step_done = 1'b0; hs.step_hit = 1'b0; hs.step_ate = 1'b0; hs.food_done = 1'b0;
        tick(2);
        rst = 1'b0;
        checkOutput("rst_state", game_state, 0);
        checkOutput("rst_step_req", hs.step_req, 0);
        checkOutput("rst_food_req", hs.food_req, 0);
        checkOutput("rst_game_clr", hs.game_clr, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_speed", speed, INIT);
        checkOutput("rst_step_dir", hs.step_dir, 3);
    endtask

    task automatic startGame();
        start = 1'b1;
        waitHigh(2, 4, "game_clr");
        checkOutput("food_req_at_start", hs.food_req, 1);
        m_foods    = 0;
        m_dir_cur  = 3;
        m_dir_pend = 3;
        tick();
        start = 1'b0;
        checkOutput("game_clr_pulse", hs.game_clr, 0);
        checkOutput("start_score", score, 0);
        checkOutput("start_speed", speed, INIT);
        checkOutput("start_state", game_state, 1);
    endtask

    task automatic serveFood();
        waitHigh(1, 4, "food_req");
        tick($urandom_range(0, 3));
        checkOutput("food_req_held", hs.food_req, 1);
        hs.food_done = 1'b1;
        tick();
        hs.food_done = 1'b0;
        checkOutput("food_req_drop", hs.food_req, 0);
        checkOutput("wait_state", game_state, 1);
    endtask

    task automatic runFrames();
        int sp = modelSpeed();
        for (int i = 0; i < sp; i++) begin
            if (i > 0) tick($urandom_range(0, 2));
            if (i == sp - 1) checkOutput("no_early_step", hs.step_req, 0);
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
        waitHigh(0, 4, "step_req");
        checkOutput("step_dir", hs.step_dir, m_dir_pend);
        m_dir_cur = m_dir_pend;
    endtask

    task automatic finishStep(input bit hit, input bit ate, input bit with_tick);
        tick($urandom_range(0, 3));
        checkOutput("step_req_held", hs.step_req, 1);
        hs.step_done = 1'b1;
        hs.step_hit  = hit;
        hs.step_ate  = ate;
        frame_tick   = with_tick;
        tick();
        hs.step_done = 1'b0; hs.step_hit = 1'b0; hs.step_ate = 1'b0;
        frame_tick   = 1'b0;
        checkOutput("step_req_drop", hs.step_req, 0);
        if (hit) begin
            checkOutput("over_state", game_state, 2);
            checkOutput("over_food_req", hs.food_req, 0);
        end else begin
            if (ate) m_foods++;
            checkOutput("run_state", game_state, 1);
            checkOutput("food_req_after_move", hs.food_req, ate ? 1 : 0);
        end
        checkOutput("score", score, modelScore());
        checkOutput("speed", speed, modelSpeed());
    endtask

    initial begin
        $display("[TB] start");

        // 1: reset, start, first food, first move to the right
        resetDut();
        startGame();
        serveFood();
        runFrames();
        finishStep(1'b0, 1'b0, 1'b0);

        // 2: opposite press ignored; accepted press; press during a move
        applyStimulus(2, 1'b1);
        runFrames();
        finishStep(1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1);
        runFrames();
        finishStep(1'b0, 1'b0, 1'b1);
        applyStimulus(1, 1'b1);
        runFrames();
        applyStimulus(3, 1'b1);
        checkOutput("step_dir_stable", hs.step_dir, 0);
        checkOutput("step_req_during_press", hs.step_req, 1);
        finishStep(1'b0, 1'b0, 1'b0);

        // stray done pulses with nothing outstanding
        hs.step_done = 1'b1; hs.step_hit = 1'b1; hs.food_done = 1'b1;
        tick();
        hs.step_done = 1'b0; hs.step_hit = 1'b0; hs.food_done = 1'b0;
        checkOutput("stray_done_state", game_state, 1);
        checkOutput("stray_done_req", hs.step_req, 0);

        // 3: randomized play, eating up to score saturation
        for (int n = 0; n < 40 && m_foods < MAXS + 2; n++) begin
            bit ate;
            if ($urandom_range(0, 2) == 0) applyStimulus($urandom_range(0, 3), 1'b1);
            ate = (n % 5 != 4);
            runFrames();
            finishStep(1'b0, ate, 1'($urandom_range(0, 1)));
            if (ate) serveFood();
            if (m_foods == EVERY) checkOutput("speed_after_4", speed, INIT - 1);
        end
        checkOutput("speed_floor", speed, MIN);
        checkOutput("score_saturated", score, MAXS);

        // 4: hit with ate -> OVER, then restart needs a fresh start edge
        runFrames();
        finishStep(1'b1, 1'b1, 1'b0);
        tick(5);
        checkOutput("over_frozen_state", game_state, 2);
        checkOutput("over_frozen_score", score, modelScore());
        checkOutput("over_no_food", hs.food_req, 0);
        start = 1'b1;
        tick();
        checkOutput("back_to_idle", game_state, 0);
        tick(3);
        checkOutput("held_start_idle", game_state, 0);
        checkOutput("held_start_no_clr", hs.game_clr, 0);
        start = 1'b0;
        tick();
        startGame();

        // 5: withheld step_done, then reset mid-handshake
        serveFood();
        runFrames();
        for (int i = 0; i < 100; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
        checkOutput("stuck_step_req", hs.step_req, 1);
        checkOutput("stuck_step_dir", hs.step_dir, m_dir_cur);
        rst = 1'b1;
        tick();
        checkOutput("rst_drops_req", hs.step_req, 0);
        resetDut();

        // 6: bounce ignored, stable press taken
        startGame();
        serveFood();
        applyStimulus(0, 1'b0);
        runFrames();
        finishStep(1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1);
        runFrames();
        finishStep(1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
